// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver.
// Collects WIDTH bits MSB-first from a qualified serial stream and hands each
// completed word to a double-buffered holding register with a valid/ack
// handshake. Words completed while the holding register is still full are
// dropped and flagged on the sticky Overrun output.
module serial_word_rx #(
    parameter int WIDTH = 4
) (
    input  logic                         Clk,
    input  logic                         ResetB,
    input  logic                         SerIn,
    input  logic                         SerValid,
    input  logic                         Flush,
    output logic [WIDTH-1:0]             Dout,
    output logic                         DoutValid,
    input  logic                         DoutAck,
    output logic                         Overrun,
    input  logic                         ClrOvr,
    output logic [$clog2(WIDTH+1)-1:0]   BitCnt
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_n;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] dout_n;
    logic             valid_n;
    logic             ovr_n;
    logic [CW-1:0]    cnt_n;
    logic             complete;

    // Next-state: bit collection, word completion, holding-register handshake
    // and overrun tracking.
    always_comb begin
        state_n  = state;
        sr_n     = sr;
        cnt_n    = BitCnt;
        dout_n   = Dout;
        valid_n  = DoutValid;
        ovr_n    = Overrun;
        complete = 1'b0;
        word     = {sr[WIDTH-2:0], SerIn};

        // Flush discards the partial word and outranks sampling.
        if (Flush) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (SerValid) begin
            sr_n = word;
            if (state == IDLE) begin
                state_n = RECV;
                cnt_n   = CW'(1);
            end else if (BitCnt == CW'(WIDTH - 1)) begin
                complete = 1'b1;
                state_n  = IDLE;
                cnt_n    = '0;
            end else begin
                cnt_n = BitCnt + CW'(1);
            end
        end

        // Clear first so that a drop on the same edge leaves Overrun set.
        if (ClrOvr) begin
            ovr_n = 1'b0;
        end

        if (complete) begin
            if (!DoutValid || DoutAck) begin
                dout_n  = word;
                valid_n = 1'b1;
            end else begin
                ovr_n = 1'b1;
            end
        end else if (DoutAck && DoutValid) begin
            valid_n = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!ResetB) begin
            state     <= IDLE;
            sr        <= '0;
            BitCnt    <= '0;
            Dout      <= '0;
            DoutValid <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            BitCnt    <= cnt_n;
            Dout      <= dout_n;
            DoutValid <= valid_n;
            Overrun   <= ovr_n;
        end
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// Testbench for serial_word_rx (WIDTH=4): directed vector table, hand-written
// corner sequences, then randomized traffic against a queue-based model.
module tb_serial_word_rx;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          Clk;
    logic          ResetB;
    logic          SerIn;
    logic          SerValid;
    logic          Flush;
    logic [W-1:0]  Dout;
    logic          DoutValid;
    logic          DoutAck;
    logic          Overrun;
    logic          ClrOvr;
    logic [CW-1:0] BitCnt;

    serial_word_rx #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .ResetB    (ResetB),
        .SerIn     (SerIn),
        .SerValid  (SerValid),
        .Flush     (Flush),
        .Dout      (Dout),
        .DoutValid (DoutValid),
        .DoutAck   (DoutAck),
        .Overrun   (Overrun),
        .ClrOvr    (ClrOvr),
        .BitCnt    (BitCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic rstb, sv, si, fl, ack, clr;
        int   dout, v, o, cnt;
    } vec_t;

    vec_t tbl[$];
    int   passed = 0;
    int   total  = 0;

    // Reference model: partial word as a queue of bits, plus holding state.
    int m_bits[$];
    int m_dout, m_valid, m_ovr;

    function automatic void add(logic rstb, logic sv, logic si, logic fl, logic ack,
                                logic clr, int dout, int v, int o, int cnt);
        vec_t r;
        r.rstb = rstb; r.sv = sv; r.si = si; r.fl = fl; r.ack = ack; r.clr = clr;
        r.dout = dout; r.v = v; r.o = o; r.cnt = cnt;
        tbl.push_back(r);
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step(logic rstb, logic sv, logic si, logic fl, logic ack, logic clr);
        int word;
        bit done;
        bit drop;
        if (!rstb) begin
            m_bits.delete();
            m_dout = 0; m_valid = 0; m_ovr = 0;
            return;
        end
        done = 0; drop = 0; word = 0;
        if (fl) begin
            m_bits.delete();
        end else if (sv) begin
            m_bits.push_back(int'(si));
            if (m_bits.size() == W) begin
                foreach (m_bits[i]) word = word * 2 + m_bits[i];
                m_bits.delete();
                done = 1;
            end
        end
        if (done) begin
            if (m_valid == 0 || ack) begin
                m_dout = word; m_valid = 1;
            end else begin
                drop = 1;
            end
        end else if (ack && m_valid != 0) begin
            m_valid = 0;
        end
        if (drop) m_ovr = 1;
        else if (clr) m_ovr = 0;
    endtask

    task automatic apply(logic rstb, logic sv, logic si, logic fl, logic ack, logic clr);
        ResetB = rstb; SerValid = sv; SerIn = si; Flush = fl; DoutAck = ack; ClrOvr = clr;
        model_step(rstb, sv, si, fl, ack, clr);
        @(posedge Clk);
        #1;
    endtask

    task automatic check_vals(string tag, int dout, int v, int o, int cnt);
        chk({tag, ".Dout"},      int'(Dout),      dout);
        chk({tag, ".DoutValid"}, int'(DoutValid), v);
        chk({tag, ".Overrun"},   int'(Overrun),   o);
        chk({tag, ".BitCnt"},    int'(BitCnt),    cnt);
    endtask

    task automatic send_word(int w, int ack_last, int clr_last);
        for (int i = W - 1; i >= 0; i--) begin
            apply(1, 1, logic'((w >> i) & 1), 0,
                  (i == 0) ? logic'(ack_last) : 1'b0,
                  (i == 0) ? logic'(clr_last) : 1'b0);
        end
    endtask

    initial begin
        ResetB = 0; SerValid = 0; SerIn = 0; Flush = 0; DoutAck = 0; ClrOvr = 0;

        //    rstb sv si fl ack clr   dout v o cnt
        // reset with activity on the inputs
        add(0, 1, 1, 0, 0, 0,      0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0,      0, 0, 0, 0);
        // single word 1011, then ack
        add(1, 1, 1, 0, 0, 0,      0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0,      0, 0, 0, 2);
        add(1, 1, 1, 0, 0, 0,      0, 0, 0, 3);
        add(1, 1, 1, 0, 0, 0,     11, 1, 0, 0);
        add(1, 0, 0, 0, 1, 0,     11, 0, 0, 0);
        // gapped 0110, three idle cycles between bits
        add(1, 1, 0, 0, 0, 0,     11, 0, 0, 1);
        add(1, 0, 1, 0, 0, 0,     11, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0,     11, 0, 0, 1);
        add(1, 0, 1, 0, 0, 0,     11, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0,     11, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0,     11, 0, 0, 2);
        add(1, 0, 1, 0, 0, 0,     11, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0,     11, 0, 0, 2);
        add(1, 1, 1, 0, 0, 0,     11, 0, 0, 3);
        add(1, 0, 0, 0, 0, 0,     11, 0, 0, 3);
        add(1, 0, 1, 0, 0, 0,     11, 0, 0, 3);
        add(1, 0, 0, 0, 0, 0,     11, 0, 0, 3);
        add(1, 1, 0, 0, 0, 0,      6, 1, 0, 0);
        add(1, 0, 0, 0, 1, 0,      6, 0, 0, 0);
        // 1100 unacked, then 0011 is dropped
        add(1, 1, 1, 0, 0, 0,      6, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0,      6, 0, 0, 2);
        add(1, 1, 0, 0, 0, 0,      6, 0, 0, 3);
        add(1, 1, 0, 0, 0, 0,     12, 1, 0, 0);
        add(1, 1, 0, 0, 0, 0,     12, 1, 0, 1);
        add(1, 1, 0, 0, 0, 0,     12, 1, 0, 2);
        add(1, 1, 1, 0, 0, 0,     12, 1, 0, 3);
        add(1, 1, 1, 0, 0, 0,     12, 1, 1, 0);
        // clear overrun, then 1111 with ack on its completion edge
        add(1, 0, 0, 0, 0, 1,     12, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0,     12, 1, 0, 1);
        add(1, 1, 1, 0, 0, 0,     12, 1, 0, 2);
        add(1, 1, 1, 0, 0, 0,     12, 1, 0, 3);
        add(1, 1, 1, 0, 1, 0,     15, 1, 0, 0);
        // ack, then 1,1, flush (SerIn=0 ignored), then 0101
        add(1, 0, 0, 0, 1, 0,     15, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0,     15, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0,     15, 0, 0, 2);
        add(1, 1, 0, 1, 0, 0,     15, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0,     15, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0,     15, 0, 0, 2);
        add(1, 1, 0, 0, 0, 0,     15, 0, 0, 3);
        add(1, 1, 1, 0, 0, 0,      5, 1, 0, 0);
        // ack, hold 1001, two bits into the next word, then reset
        add(1, 0, 0, 0, 1, 0,      5, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0,      5, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0,      5, 0, 0, 2);
        add(1, 1, 0, 0, 0, 0,      5, 0, 0, 3);
        add(1, 1, 1, 0, 0, 0,      9, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0,      9, 1, 0, 1);
        add(1, 1, 1, 0, 0, 0,      9, 1, 0, 2);
        add(0, 1, 1, 1, 1, 0,      0, 0, 0, 0);
        // clean 0111 after reset
        add(1, 1, 0, 0, 0, 0,      0, 0, 0, 1);
        add(1, 1, 1, 0, 0, 0,      0, 0, 0, 2);
        add(1, 1, 1, 0, 0, 0,      0, 0, 0, 3);
        add(1, 1, 1, 0, 0, 0,      7, 1, 0, 0);
        // flush still honours ack on the same edge
        add(1, 1, 1, 1, 1, 0,      7, 0, 0, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].rstb, tbl[i].sv, tbl[i].si, tbl[i].fl, tbl[i].ack, tbl[i].clr);
            check_vals($sformatf("vec%0d", i), tbl[i].dout, tbl[i].v, tbl[i].o, tbl[i].cnt);
        end

        // Drop and ClrOvr on the same edge: the drop wins.
        send_word(4'b1010, 0, 0);
        check_vals("load_A", 10, 1, 0, 0);
        send_word(4'b0101, 0, 1);
        check_vals("drop_vs_clr", 10, 1, 1, 0);
        apply(1, 0, 0, 0, 0, 1);
        check_vals("clr_after", 10, 1, 0, 0);
        // Ack with nothing held is ignored; back-to-back words with acks.
        apply(1, 0, 0, 0, 1, 0);
        apply(1, 0, 0, 0, 1, 0);
        check_vals("ack_idle", 10, 0, 0, 0);
        send_word(4'b0011, 0, 0);
        send_word(4'b1110, 1, 0);
        check_vals("b2b_ack", 14, 1, 0, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic rstb, sv, si, fl, ack, clr;
            rstb = ($urandom_range(0, 199) != 0);
            sv   = ($urandom_range(0, 3) != 0);
            si   = logic'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 19) == 0);
            ack  = ($urandom_range(0, 2) == 0);
            clr  = ($urandom_range(0, 9) == 0);
            apply(rstb, sv, si, fl, ack, clr);
            check_vals($sformatf("rnd%0d", n), m_dout, m_valid, m_ovr, m_bits.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel receiver sitting directly downstream of the 4-bit shift-register stage. It samples the serial bit stream that stage shifts out and reassembles it into WIDTH-bit words, MSB first. Each completed word is presented on a holding register with a valid/ack handshake. Receive and hold are double-buffered, so the next word can arrive while the previous one waits to be acknowledged.

## Interface
- WIDTH, 4, word width in bits (legal range 2..16).
- Clk  in  1  rising-edge clock; the only clock.
- ResetB  in  1  synchronous, active-low reset, sampled on rising Clk.
- SerIn  in  1  serial data bit.
- SerValid  in  1  SerIn is sampled on an edge only when this is 1.
- Flush  in  1  synchronous discard of any partially received word.
- Dout  out  WIDTH  holding register; last completed word.
- DoutValid  out  1  Dout holds an unacknowledged word.
- DoutAck  in  1  consumer accepts Dout; meaningful only when DoutValid=1.
- Overrun  out  1  sticky; a completed word was dropped.
- ClrOvr  in  1  synchronous clear of Overrun.
- BitCnt  out  ceil(log2(WIDTH+1))  bits collected in the current partial word.

Clock and reset are fixed: one clock; reset is synchronous and active-low (ports Clk and ResetB).

## Operation
- Internal shift register SR[WIDTH-1:0]. On a sampling edge, SR <= {SR[WIDTH-2:0], SerIn}. The first bit received ends in the MSB.
- Receive FSM:
  - IDLE (BitCnt=0): a sampling edge moves it to RECV with BitCnt=1.
  - RECV: each sampling edge increments BitCnt. The edge that samples bit WIDTH is the completion edge. At that edge BitCnt returns to 0 and the FSM returns to IDLE.
  - SerValid=0 holds the state. There is no timeout.
- Completion edge, with the word being {SR[WIDTH-2:0], SerIn}:
  - Holding register empty (DoutValid=0), or DoutAck=1 on the same edge: Dout <= word and DoutValid <= 1.
  - Holding register full and DoutAck=0: the word is dropped, Overrun <= 1, and Dout is unchanged.
- DoutAck=1 with DoutValid=1 and no completion edge: DoutValid <= 0. Dout keeps its last value.
- DoutAck while DoutValid=0 is ignored.
- Flush=1: BitCnt <= 0, FSM goes to IDLE, and SerIn on that edge is ignored. Flush has priority over sampling. The holding register, DoutValid and Overrun are unaffected, and DoutAck is still honoured on that edge.
- Overrun handling:
  - Overrun is set only by a drop.
  - ClrOvr clears it.
  - If a drop and ClrOvr occur on the same edge, the set wins and Overrun=1.

## Timing
- Reset, when ResetB=0 on a rising edge:
  - Outputs: Dout=0, DoutValid=0, Overrun=0, BitCnt=0.
  - Internal: SR=0, FSM=IDLE.
  - Reset overrides Flush, SerValid and DoutAck.
  - Asserting reset mid-word discards the partial word and any held word.
- Latency: DoutValid and Dout update on the completion edge itself and are visible in the following cycle. There is no added pipeline stage.
- Throughput: back-to-back words with SerValid held at 1 are supported, one word per WIDTH cycles. This requires DoutAck to arrive no later than the next completion edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- BitCnt never reaches WIDTH. It wraps directly from WIDTH-1 to 0 on the completion edge.

## Test plan
- **Reset value check.** Hold ResetB=0 for 2 cycles with SerValid=1 and SerIn=1 → Dout=0, DoutValid=0, Overrun=0, BitCnt=0.
- **Single word.** Send bits 1,0,1,1 on 4 consecutive SerValid cycles → the cycle after the 4th edge shows Dout=4'b1011 and DoutValid=1. Then pulse DoutAck for 1 cycle → DoutValid=0 and Dout stays 4'b1011.
- **Gapped input.** Send 0,1,1,0 with SerValid=0 for 3 cycles between each bit → Dout=4'b0110. BitCnt holds its value during the gaps.
- **Overrun, then recovery.**
  - Send 4'b1100 with no ack, then send 4'b0011 → Dout=4'b1100 and Overrun=1.
  - Pulse ClrOvr → Overrun=0.
  - Send 4'b1111 with DoutAck asserted on its completion edge → Dout=4'b1111, DoutValid=1, and Overrun remains 0.
- **Flush mid-word.** Send 1,1, pulse Flush with SerValid=1 and SerIn=0, then send 0,1,0,1 → Dout=4'b0101 and no overrun.
- **Reset mid-operation.** Hold a word 4'b1001 unacknowledged and 2 bits into the next word, then apply ResetB=0 for 1 cycle → all outputs return to 0. A following 4'b0111 is received cleanly.
